// File: rtl/csa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : csa_pkg
//  Purpose  : Shared widths, the carry-save row type and a helper that gives
//             the number of rows left after each 3:2 reduction level of the
//             ten-operand adder.
//  Contents : OP_W, N_OPS, SUM_W, ROW_W, N_LEVELS, csa_row_t, rows_at()
//  Revision : 1.0  initial release
// ============================================================================
package csa_pkg;

  localparam int OP_W     = 8;   // operand width
  localparam int N_OPS    = 10;  // number of operands
  localparam int SUM_W    = 18;  // width of the registered sum
  localparam int ROW_W    = 12;  // 10 * 255 = 2550 < 4096
  localparam int N_LEVELS = 5;   // 10 -> 7 -> 5 -> 4 -> 3 -> 2

  typedef logic [ROW_W-1:0] csa_row_t;

  // Rows present at the input of level lvl. Each level groups the rows in
  // threes, and every group of three becomes two rows. Rows that do not fill
  // a group are passed through unchanged.
  function automatic int rows_at(input int lvl);
    int n;
    n = N_OPS;
    for (int k = 0; k < lvl; k++) begin
      n = n - (n / 3);
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csa_fa.sv
`default_nettype none
// ============================================================================
//  Module   : csa_fa
//  Purpose  : 1-bit full adder. It is used as the 3:2 compressor cell and as
//             the ripple cell of the carry-propagate adder.
//  Ports    : x, y, z  - addend bits
//             sum      - x ^ y ^ z
//             cout     - majority(x, y, z)
//  Revision : 1.0  initial release
// ============================================================================
module csa_fa (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic sum,
  output logic cout
);

  assign sum  = x ^ y ^ z;
  assign cout = (x & y) | (x & z) | (y & z);

endmodule
`default_nettype wire

// File: rtl/csa_sum10.sv
`default_nettype none
// ============================================================================
//  Module   : csa_sum10
//  Purpose  : Adds ten unsigned 8-bit operands. A 3:2 carry-save tree reduces
//             the operands to two rows (10->7->5->4->3->2). A 12-bit ripple
//             carry-propagate adder then adds those two rows, and the result
//             is registered as an 18-bit sum.
//  Ports    : clk          - clock, rising edge
//             rst_n        - asynchronous active-low reset
//             a .. j       - 8-bit unsigned operands, sampled every edge
//             s            - 18-bit registered sum (s[17:12] always 0)
//  Options  : CSA_PIPE_EN  - when defined, the two carry-save rows are
//                            registered ahead of the carry-propagate adder.
//                            Latency becomes 2 cycles. When undefined, the
//                            latency is 1 cycle.
//  Revision : 1.0  initial release
// ============================================================================
module csa_sum10
  import csa_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  input  logic [OP_W-1:0]  c,
  input  logic [OP_W-1:0]  d,
  input  logic [OP_W-1:0]  e,
  input  logic [OP_W-1:0]  f,
  input  logic [OP_W-1:0]  g,
  input  logic [OP_W-1:0]  h,
  input  logic [OP_W-1:0]  i,
  input  logic [OP_W-1:0]  j,
  output logic [SUM_W-1:0] s
);

  // tree[l][r] is row r at the input of level l. Slots above the live row
  // count of a level are tied to zero and never read.
  csa_row_t        tree [N_LEVELS+1][N_OPS];
  logic [OP_W-1:0] ops  [N_OPS];

  assign ops = '{a, b, c, d, e, f, g, h, i, j};

  for (genvar n = 0; n < N_OPS; n++) begin : g_load
    assign tree[0][n] = ROW_W'(ops[n]);
  end

  // --------------------------------------------------------------------------
  // Carry-save reduction tree
  // --------------------------------------------------------------------------
  for (genvar l = 0; l < N_LEVELS; l++) begin : g_level
    localparam int N_IN  = rows_at(l);
    localparam int N_GRP = N_IN / 3;
    localparam int N_OUT = N_IN - N_GRP;

    for (genvar k = 0; k < N_GRP; k++) begin : g_grp
      logic [ROW_W-2:0] sm;
      logic [ROW_W-2:0] cy;

      for (genvar bt = 0; bt < ROW_W-1; bt++) begin : g_bit
        csa_fa u_fa (
          .x    (tree[l][3*k][bt]),
          .y    (tree[l][3*k+1][bt]),
          .z    (tree[l][3*k+2][bt]),
          .sum  (sm[bt]),
          .cout (cy[bt])
        );
      end

      // A carry out of the top column would weigh 2^12. Every row is bounded
      // by the total sum (<= 2550), so that carry is always 0. Only the sum
      // bit is formed for the top column.
      assign tree[l+1][2*k]   = {tree[l][3*k][ROW_W-1] ^ tree[l][3*k+1][ROW_W-1]
                                 ^ tree[l][3*k+2][ROW_W-1], sm};
      assign tree[l+1][2*k+1] = {cy, 1'b0};
    end

    for (genvar p = 0; p < N_IN - 3*N_GRP; p++) begin : g_pass
      assign tree[l+1][2*N_GRP+p] = tree[l][3*N_GRP+p];
    end

    for (genvar o = N_OUT; o < N_OPS; o++) begin : g_idle
      assign tree[l+1][o] = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Optional register between the tree and the carry-propagate adder
  // --------------------------------------------------------------------------
  csa_row_t cpa_x;
  csa_row_t cpa_y;

`ifdef CSA_PIPE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpa_x <= '0;
      cpa_y <= '0;
    end else begin
      cpa_x <= tree[N_LEVELS][0];
      cpa_y <= tree[N_LEVELS][1];
    end
  end
`else
  assign cpa_x = tree[N_LEVELS][0];
  assign cpa_y = tree[N_LEVELS][1];
`endif

  // --------------------------------------------------------------------------
  // 12-bit ripple carry-propagate adder
  // --------------------------------------------------------------------------
  csa_row_t cpa_sum;
  logic [ROW_W-1:0] rc;

  assign rc[0] = 1'b0;

  for (genvar bt = 0; bt < ROW_W-1; bt++) begin : g_cpa
    csa_fa u_fa (
      .x    (cpa_x[bt]),
      .y    (cpa_y[bt]),
      .z    (rc[bt]),
      .sum  (cpa_sum[bt]),
      .cout (rc[bt+1])
    );
  end

  // The result fits in 12 bits, so the final carry out is always 0.
  assign cpa_sum[ROW_W-1] = cpa_x[ROW_W-1] ^ cpa_y[ROW_W-1] ^ rc[ROW_W-1];

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0;
    end else begin
      s <= SUM_W'(cpa_sum);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csa_sum10.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csa_sum10
//  Purpose  : Self-checking bench for csa_sum10. The reference model sums the
//             ten operands with integer arithmetic. A delay line of the
//             configured latency turns each sum into the expected value of s.
//             Define CSA_PIPE_EN to check the two-cycle build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_csa_sum10;

`ifdef CSA_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  ops [10];
  logic [17:0] s;

  int checks;
  int errors;
  int q[$];   // expected outputs; q[0] is the value s should hold now

  csa_sum10 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (ops[0]),
    .b     (ops[1]),
    .c     (ops[2]),
    .d     (ops[3]),
    .e     (ops[4]),
    .f     (ops[5]),
    .g     (ops[6]),
    .h     (ops[7]),
    .i     (ops[8]),
    .j     (ops[9]),
    .s     (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_sum();
    int acc;
    acc = 0;
    for (int k = 0; k < 10; k++) acc += int'(ops[k]);
    return acc;
  endfunction

  task automatic model_clear();
    q = {};
    for (int k = 0; k < LAT; k++) q.push_back(0);
  endtask

  task automatic set_ops(input int v0, input int v1, input int v2, input int v3,
                         input int v4, input int v5, input int v6, input int v7,
                         input int v8, input int v9);
    ops[0] = 8'(v0); ops[1] = 8'(v1); ops[2] = 8'(v2); ops[3] = 8'(v3);
    ops[4] = 8'(v4); ops[5] = 8'(v5); ops[6] = 8'(v6); ops[7] = 8'(v7);
    ops[8] = 8'(v8); ops[9] = 8'(v9);
  endtask

  task automatic rand_ops();
    for (int k = 0; k < 10; k++) ops[k] = 8'($urandom_range(0, 255));
  endtask

  // One clock edge. The model advances, and s is checked 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    if (rst_n) begin
      q.push_back(ref_sum());
      void'(q.pop_front());
    end
    #1;
    check(tag, int'(s), q[0]);
  endtask

  // Holds one vector for LAT edges, then compares s with a fixed constant.
  task automatic hold_vec(input string tag, input int exp);
    for (int k = 0; k < LAT; k++) step({tag, "_mdl"});
    check(tag, int'(s), exp);
    check({tag, "_hi"}, int'(s[17:12]), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    rand_ops();
    model_clear();

    // Reset holds s at zero while the operands vary.
    repeat (2) begin
      @(posedge clk);
      #1;
      rand_ops();
      check("reset", int'(s), 0);
    end

    // Release reset mid-cycle. The first edge then produces a valid sum.
    rst_n = 1'b1;
    set_ops(1, 2, 3, 4, 5, 6, 7, 8, 9, 10);
    hold_vec("first", 55);

    set_ops(11, 2, 13, 4, 5, 6, 7, 8, 9, 10);       hold_vec("vec75", 75);
    set_ops(3, 14, 5, 6, 7, 8, 19, 10, 0, 0);       hold_vec("vec72", 72);
    set_ops(30, 22, 19, 126, 5, 92, 69, 44, 1, 10); hold_vec("vec418", 418);
    set_ops(255, 255, 255, 255, 255, 255, 255, 255, 255, 254);
    hold_vec("max_m1", 2549);
    set_ops(255, 255, 255, 255, 255, 255, 255, 255, 255, 255);
    hold_vec("max", 2550);
    set_ops(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);          hold_vec("zero", 0);

    // Operand changes between edges must not disturb s.
    set_ops(30, 22, 19, 126, 5, 92, 69, 44, 1, 10);
    step("pre_hold");
    rand_ops();
    #3;
    check("hold_between_edges", int'(s), q[0]);

    // Back-to-back stream, with reset asserted mid-stream.
    set_ops(11, 2, 13, 4, 5, 6, 7, 8, 9, 10);       step("stream1");
    set_ops(3, 14, 5, 6, 7, 8, 19, 10, 0, 0);       step("stream2");
    set_ops(30, 22, 19, 126, 5, 92, 69, 44, 1, 10); step("stream3");
    set_ops(255, 255, 255, 255, 255, 255, 255, 255, 255, 254);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", int'(s), 0);
    model_clear();
    step("in_reset");
    rst_n = 1'b1;
    set_ops(11, 2, 13, 4, 5, 6, 7, 8, 9, 10);       step("restart1");
    set_ops(3, 14, 5, 6, 7, 8, 19, 10, 0, 0);       step("restart2");
    set_ops(30, 22, 19, 126, 5, 92, 69, 44, 1, 10); step("restart3");
    set_ops(255, 255, 255, 255, 255, 255, 255, 255, 255, 254);
    step("restart4");
    for (int k = 0; k < LAT; k++) step("flush");

    // Random streaming against the reference model.
    for (int n = 0; n < 300; n++) begin
      if (n % 8 == 0) begin
        for (int k = 0; k < 10; k++) ops[k] = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'($urandom_range(200, 255));
      end else begin
        rand_ops();
      end
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
